// File: rtl/dist_calc_ctrl.sv
// Stereo distance measurement sequencer: gates calc-buffer capture, scans both
// calc RAMs into the correlator and latches the resulting disparity.
module dist_calc_ctrl #(
  parameter int          ROW_LEN = 79,
  parameter int          ROWS    = 16,
  parameter logic [23:0] TIMEOUT = 24'd2000000
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        start,
  input  logic        auto,
  input  logic        left_done,
  input  logic        right_done,
  output logic        calc_en,
  output logic [10:0] rdaddr,
  output logic        rden,
  input  logic        eng_ready,
  output logic        pix_valid,
  output logic        pix_last,
  input  logic        eng_done,
  input  logic [9:0]  eng_result,
  output logic [9:0]  dist_out,
  output logic        dist_valid,
  output logic        busy,
  output logic        err_timeout
);

  localparam logic [10:0] LAST_ADDR = 11'(ROW_LEN * ROWS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CAPTURE  = 3'd1,
    READ     = 3'd2,
    DRAIN    = 3'd3,
    WAIT_ENG = 3'd4
  } state_t;

  state_t      state_r;
  logic        left_got_r;
  logic        right_got_r;
  logic [23:0] tmo_cnt_r;
  logic        both_got_s;
  logic        last_rd_s;

  // Capture completion includes done pulses arriving in the current cycle
  always_comb begin
    both_got_s = (left_got_r | left_done) & (right_got_r | right_done);
    last_rd_s  = rden & (rdaddr == LAST_ADDR);
  end

  // Measurement sequencer with registered outputs
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_r     <= IDLE;
      left_got_r  <= 1'b0;
      right_got_r <= 1'b0;
      tmo_cnt_r   <= 24'd0;
      calc_en     <= 1'b0;
      rdaddr      <= 11'd0;
      rden        <= 1'b0;
      pix_valid   <= 1'b0;
      pix_last    <= 1'b0;
      dist_out    <= 10'd0;
      dist_valid  <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      dist_valid <= 1'b0;
      // RAM read latency is one cycle, so data qualifiers trail the strobe
      pix_valid  <= rden;
      pix_last   <= last_rd_s;
      case (state_r)
        IDLE: begin
          if (start || auto) begin
            state_r     <= CAPTURE;
            calc_en     <= 1'b1;
            busy        <= 1'b1;
            left_got_r  <= 1'b0;
            right_got_r <= 1'b0;
            tmo_cnt_r   <= 24'd0;
            if (start) begin
              err_timeout <= 1'b0;
            end
          end
        end
        CAPTURE: begin
          if (both_got_s) begin
            state_r <= READ;
            calc_en <= 1'b0;
            rden    <= eng_ready;
            rdaddr  <= 11'd0;
          end else if (tmo_cnt_r == TIMEOUT - 24'd1) begin
            state_r     <= IDLE;
            calc_en     <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b1;
          end else begin
            tmo_cnt_r   <= tmo_cnt_r + 24'd1;
            left_got_r  <= left_got_r | left_done;
            right_got_r <= right_got_r | right_done;
          end
        end
        READ: begin
          if (last_rd_s) begin
            state_r <= DRAIN;
            rden    <= 1'b0;
            rdaddr  <= 11'd0;
          end else begin
            rden <= eng_ready;
            if (rden) begin
              rdaddr <= rdaddr + 11'd1;
            end
          end
        end
        DRAIN: begin
          state_r <= WAIT_ENG;
        end
        WAIT_ENG: begin
          if (eng_done) begin
            state_r    <= IDLE;
            dist_out   <= eng_result;
            dist_valid <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          calc_en <= 1'b0;
          rden    <= 1'b0;
          rdaddr  <= 11'd0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dist_calc_ctrl.sv
// Directed bench for dist_calc_ctrl: full scans, pacing, timeout, abort and auto mode.
module tb_dist_calc_ctrl;

  logic        sysclk = 1'b0;
  logic        reset, start, auto, left_done, right_done, eng_ready, eng_done;
  logic [9:0]  eng_result;
  logic        calc_en, rden, pix_valid, pix_last, dist_valid, busy, err_timeout;
  logic [10:0] rdaddr;
  logic [9:0]  dist_out;

  int total = 0;
  int bad   = 0;
  int n;

  logic mon_clr;
  int   exp_addr, addr_err, rd_cnt, pv_cnt, last_at, dv_cnt;

  always #5 sysclk = ~sysclk;

  dist_calc_ctrl #(.TIMEOUT(24'd100)) dut (
    .sysclk(sysclk), .reset(reset), .start(start), .auto(auto),
    .left_done(left_done), .right_done(right_done), .calc_en(calc_en),
    .rdaddr(rdaddr), .rden(rden), .eng_ready(eng_ready),
    .pix_valid(pix_valid), .pix_last(pix_last), .eng_done(eng_done),
    .eng_result(eng_result), .dist_out(dist_out), .dist_valid(dist_valid),
    .busy(busy), .err_timeout(err_timeout)
  );

  // Scan monitor: address order, strobe and pixel counts, result pulses
  always @(negedge sysclk) begin
    if (mon_clr) begin
      exp_addr <= 0; addr_err <= 0; rd_cnt <= 0; pv_cnt <= 0; last_at <= 0; dv_cnt <= 0;
    end else begin
      if (rden) begin
        if (rdaddr != 11'(exp_addr)) addr_err <= addr_err + 1;
        exp_addr <= exp_addr + 1;
        rd_cnt   <= rd_cnt + 1;
      end
      if (pix_valid) pv_cnt <= pv_cnt + 1;
      if (pix_last)  last_at <= pv_cnt + (pix_valid ? 1 : 0);
      if (dist_valid) dv_cnt <= dv_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic pulse_both();
    left_done = 1'b1; right_done = 1'b1;
    tick();
    left_done = 1'b0; right_done = 1'b0;
  endtask

  task automatic wait_last(input bit toggle, input bit inject);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (pix_last) begin
        seen = 1'b1;
        break;
      end
      if (toggle) eng_ready = ~eng_ready;
      if (inject && i == 300) begin
        eng_done = 1'b1; eng_result = 10'd999; start = 1'b1;
      end else if (inject && i == 301) begin
        eng_done = 1'b0; start = 1'b0;
      end
      tick();
    end
    check("pix_last_seen", 32'(seen), 32'd1);
  endtask

  task automatic finish_eng(input logic [9:0] res);
    eng_result = res; eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; auto = 1'b0; left_done = 1'b0; right_done = 1'b0;
    eng_ready = 1'b0; eng_done = 1'b0; eng_result = 10'd0; mon_clr = 1'b1;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_calc_en", 32'(calc_en), 32'd0);
    check("rst_rdaddr", 32'(rdaddr), 32'd0);
    check("rst_rden", 32'(rden), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_dist_out", 32'(dist_out), 32'd0);
    check("rst_dist_valid", 32'(dist_valid), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    reset = 1'b0; mon_clr = 1'b0;

    // Basic measurement with staggered done pulses and continuous ready
    eng_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("cap_busy", 32'(busy), 32'd1);
    check("cap_calc_en", 32'(calc_en), 32'd1);
    repeat (4) tick();
    left_done = 1'b1; tick(); left_done = 1'b0;
    repeat (3) tick();
    check("cap_wait_right", 32'(calc_en), 32'd1);
    right_done = 1'b1; tick(); right_done = 1'b0;
    check("read_rden", 32'(rden), 32'd1);
    check("read_addr0", 32'(rdaddr), 32'd0);
    check("read_calc_off", 32'(calc_en), 32'd0);
    wait_last(1'b0, 1'b0);
    repeat (19) tick();
    finish_eng(10'd37);
    check("m1_dist_valid", 32'(dist_valid), 32'd1);
    check("m1_dist_out", 32'(dist_out), 32'd37);
    check("m1_busy_low", 32'(busy), 32'd0);
    tick();
    check("m1_dv_one_cycle", 32'(dist_valid), 32'd0);
    check("m1_pv_cnt", 32'(pv_cnt), 32'd1264);
    check("m1_last_at", 32'(last_at), 32'd1264);
    check("m1_rd_cnt", 32'(rd_cnt), 32'd1264);
    check("m1_addr_err", 32'(addr_err), 32'd0);
    check("m1_dv_cnt", 32'(dv_cnt), 32'd1);

    // Simultaneous done pulses, toggling ready, stray eng_done/start mid-scan
    clear_mon();
    start = 1'b1; tick(); start = 1'b0;
    pulse_both();
    check("same_rden", 32'(rden), 32'd1);
    check("same_addr0", 32'(rdaddr), 32'd0);
    wait_last(1'b1, 1'b1);
    eng_ready = 1'b1;
    check("stray_eng_done", 32'(dist_out), 32'd37);
    repeat (5) tick();
    finish_eng(10'd512);
    check("m2_dist_out", 32'(dist_out), 32'd512);
    tick();
    check("start_not_queued", 32'(busy), 32'd0);
    check("m2_pv_cnt", 32'(pv_cnt), 32'd1264);
    check("m2_rd_cnt", 32'(rd_cnt), 32'd1264);
    check("m2_addr_err", 32'(addr_err), 32'd0);

    // Capture timeout with only the left window arriving
    clear_mon();
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      left_done = (n == 3);
      n++;
      tick();
    end
    left_done = 1'b0;
    check("tmo_cycles", 32'(n), 32'd100);
    check("tmo_err", 32'(err_timeout), 32'd1);
    check("tmo_calc_en", 32'(calc_en), 32'd0);
    check("tmo_no_rden", 32'(rd_cnt), 32'd0);
    pulse_both();
    tick();
    check("idle_done_ignored", 32'(busy), 32'd0);
    check("err_sticky", 32'(err_timeout), 32'd1);

    // Reset in the middle of a scan
    start = 1'b1; tick(); start = 1'b0;
    check("start_clears_err", 32'(err_timeout), 32'd0);
    pulse_both();
    n = 0;
    while (!(rden && rdaddr == 11'd600) && n < 2000) begin
      n++;
      tick();
    end
    check("addr600_reached", 32'(rdaddr), 32'd600);
    reset = 1'b1; tick(); reset = 1'b0;
    check("abort_rdaddr", 32'(rdaddr), 32'd0);
    check("abort_rden", 32'(rden), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (5) tick();
    check("abort_no_dv", 32'(dv_cnt), 32'd0);

    // Auto mode: two back-to-back measurements, first after the abort
    clear_mon();
    auto = 1'b1;
    tick();
    check("auto_start", 32'(busy), 32'd1);
    pulse_both();
    wait_last(1'b0, 1'b0);
    repeat (3) tick();
    finish_eng(10'd100);
    check("a1_dist_valid", 32'(dist_valid), 32'd1);
    check("a1_dist_out", 32'(dist_out), 32'd100);
    tick();
    check("a1_recapture", 32'(calc_en), 32'd1);
    check("a1_pv_cnt", 32'(pv_cnt), 32'd1264);
    check("a1_addr_err", 32'(addr_err), 32'd0);
    clear_mon();
    pulse_both();
    wait_last(1'b0, 1'b0);
    auto = 1'b0;
    repeat (3) tick();
    finish_eng(10'd200);
    check("a2_dist_valid", 32'(dist_valid), 32'd1);
    check("a2_dist_out", 32'(dist_out), 32'd200);
    tick();
    check("a2_idle", 32'(busy), 32'd0);
    check("a2_pv_cnt", 32'(pv_cnt), 32'd1264);
    check("a2_addr_err", 32'(addr_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
